// File: rtl/mem_arb_ctrl_pkg.sv
// Shared definitions for the I/D line-fill memory arbiter.
// Line geometry, FSM encoding and the per-transaction record.
package mem_arb_ctrl_pkg;

  localparam int ADDR_W     = 16;
  localparam int LINE_BEATS = 4;
  localparam int IDX_W      = $clog2(LINE_BEATS);
  localparam int OFF_W      = IDX_W + 1;
  localparam int LINE_W     = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic              side_d;
    logic              wb;
    logic [LINE_W-1:0] miss;
    logic [LINE_W-1:0] vict;
  } txn_t;

  function automatic logic [ADDR_W-1:0] beat_addr(
    input logic [LINE_W-1:0] line,
    input logic [IDX_W-1:0]  idx
  );
    return {line, idx, 1'b0};
  endfunction

endpackage

// File: rtl/mem_arb_ctrl_beat_ctr.sv
// One-hot beat sequencer: rotates on each completed beat,
// restart parks it on beat 0.
module beat_ctr
  import mem_arb_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             restart_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [LINE_BEATS-1:0] oh_q;
  logic [LINE_BEATS-1:0] oh_d;

  always_comb begin
    oh_d = oh_q;
    if (restart_i) begin
      oh_d = LINE_BEATS'(1);
    end else if (en_i) begin
      oh_d = {oh_q[LINE_BEATS-2:0],
              oh_q[LINE_BEATS-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      oh_q <= LINE_BEATS'(1);
    end else begin
      oh_q <= oh_d;
    end
  end

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < LINE_BEATS; i++) begin
      if (oh_q[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

  assign last_o = oh_q[LINE_BEATS-1];

endmodule

// File: rtl/mem_arb_ctrl.sv
// Round-robin arbiter between I-side fills and D-side
// writeback+fill, sequencing 4-beat line transfers.
module mem_arb_ctrl
  import mem_arb_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dreq,
  input  logic              dwb,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dvaddr,
  input  logic              mem_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [IDX_W-1:0]  idx,
  output logic              fill_we,
  output logic              igrant,
  output logic              dgrant,
  output logic              busy,
  output logic              done_i,
  output logic              done_d
);

  state_e state_q;
  state_e state_d;
  txn_t   txn_q;
  txn_t   txn_d;
  logic   last_d_q;
  logic   last_d_d;

  logic   in_beat;
  logic   beat_en;
  logic   beat_last;
  logic   gnt_d;

  assign in_beat = (state_q == S_WB) ||
                   (state_q == S_FILL);
  assign beat_en = in_beat && !mem_stall;

  beat_ctr u_beat (
    .clk       (clk),
    .rst       (rst),
    .en_i      (beat_en),
    .restart_i (state_q == S_IDLE),
    .idx_o     (idx),
    .last_o    (beat_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      txn_q    <= '0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      txn_q    <= txn_d;
      last_d_q <= last_d_d;
    end
  end

  // Data wins a tie unless it was the last side served.
  assign gnt_d = dreq && (!ireq || !last_d_q);

  always_comb begin
    state_d  = state_q;
    txn_d    = txn_q;
    last_d_d = last_d_q;
    unique case (state_q)
      S_IDLE: begin
        if (ireq || dreq) begin
          txn_d.side_d = gnt_d;
          txn_d.wb     = gnt_d && dwb;
          txn_d.miss   = gnt_d ? daddr[ADDR_W-1:OFF_W]
                               : iaddr[ADDR_W-1:OFF_W];
          txn_d.vict   = dvaddr[ADDR_W-1:OFF_W];
          last_d_d     = gnt_d;
          state_d      = (gnt_d && dwb) ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        if (beat_en && beat_last) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (beat_en && beat_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_addr = '0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    done_i   = 1'b0;
    done_d   = 1'b0;
    busy     = state_q != S_IDLE;
    igrant   = busy && !txn_q.side_d;
    dgrant   = busy && txn_q.side_d;
    unique case (1'b1)
      state_q == S_WB: begin
        mem_wr   = 1'b1;
        mem_addr = beat_addr(txn_q.vict, idx);
      end
      state_q == S_FILL: begin
        mem_rd   = 1'b1;
        mem_addr = beat_addr(txn_q.miss, idx);
      end
      state_q == S_DONE: begin
        done_i = !txn_q.side_d;
        done_d = txn_q.side_d;
      end
      default: begin
      end
    endcase
    fill_we = mem_rd && !mem_stall;
  end

endmodule
